fifo_rd_ctrl: RTL and testbench

Read-side controller for the team's single-clock FIFO. It owns the read pointer and compares it against the write pointer supplied by the write side. It issues reads to the FIFO storage array, which has one cycle of registered read latency, and presents the returned words on a valid/ready stream. A 2-entry output buffer sustains one word per cycle under back-pressure. The exported read pointer closes the loop for the writer's full detection.

---
 rtl/fifo_rd_ctrl.sv | 79 +++++++
 tb/tb_fifo_rd_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller for the single-clock FIFO.
// It owns the read pointer and issues reads to storage, which has one cycle of latency.
// Returned words go through a 2-entry head/skid buffer onto a valid/ready stream.
`timescale 1ns/1ps
module fifo_rd_ctrl #(
    parameter int WIDTH  = 8,
    parameter int AWIDTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [AWIDTH:0]   i_wr_ptr,
    input  logic              i_flush,
    output logic [AWIDTH:0]   o_rd_ptr,
    output logic              o_mem_re,
    output logic [AWIDTH-1:0] o_mem_addr,
    input  logic [WIDTH-1:0]  i_mem_data,
    output logic              o_valid,
    output logic [WIDTH-1:0]  o_data,
    input  logic              i_ready,
    output logic              o_empty,
    output logic [AWIDTH:0]   o_level
);

    logic [1:0]       cnt;
    logic             inf;
    logic [WIDTH-1:0] skid;
    logic             pop;
    logic [2:0]       occ;
    logic [1:0]       cnt_after_pop;

    // Occupancy bookkeeping and the read-issue decision.
    // The read strobe is gated by reset, because the writer's pointer may be nonzero while the read pointer is held at 0.
    always_comb begin
        pop           = o_valid & i_ready;
        occ           = {1'b0, cnt} + {2'b00, inf} - {2'b00, pop};
        cnt_after_pop = cnt - {1'b0, pop};
        o_empty       = (o_rd_ptr == i_wr_ptr);
        o_level       = i_wr_ptr - o_rd_ptr;
        o_mem_addr    = o_rd_ptr[AWIDTH-1:0];
        o_mem_re      = i_rst_n & ~o_empty & ~i_flush & (occ < 3'd2);
    end

    // Pointer, in-flight tracking and the head/skid buffer.
    // A flush takes priority: it discards buffered and returning words, and head keeps its old value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_ptr <= '0;
            cnt      <= '0;
            inf      <= 1'b0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            skid     <= '0;
        end else if (i_flush) begin
            o_rd_ptr <= i_wr_ptr;
            cnt      <= '0;
            inf      <= 1'b0;
            o_valid  <= 1'b0;
        end else begin
            if (o_mem_re) begin
                o_rd_ptr <= o_rd_ptr + (AWIDTH+1)'(1);
            end
            inf <= o_mem_re;
            // A pop at cnt=2 moves skid into head. A return lands in head only when the buffer is empty after the pop.
            if (pop && cnt == 2'd2) begin
                o_data <= skid;
            end
            if (inf) begin
                if (cnt_after_pop == 2'd0) begin
                    o_data <= i_mem_data;
                end else begin
                    skid <= i_mem_data;
                end
            end
            cnt     <= occ[1:0];
            o_valid <= (occ != 3'd0);
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed bench for fifo_rd_ctrl with a behavioural storage array that has one cycle of read latency.
`timescale 1ns/1ps
module tb_fifo_rd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] wr_ptr;
    logic       flush;
    logic [4:0] rd_ptr;
    logic       mem_re;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       empty;
    logic [4:0] level;

    logic [7:0] mem [16];

    int checks = 0;
    int errors = 0;

    fifo_rd_ctrl #(.WIDTH(8), .AWIDTH(4)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_wr_ptr   (wr_ptr),
        .i_flush    (flush),
        .o_rd_ptr   (rd_ptr),
        .o_mem_re   (mem_re),
        .o_mem_addr (mem_addr),
        .i_mem_data (mem_data),
        .o_valid    (valid),
        .o_data     (data),
        .i_ready    (ready),
        .o_empty    (empty),
        .o_level    (level)
    );

    always #5 clk = ~clk;

    // Storage array with one cycle of registered read latency
    always @(posedge clk) begin
        if (mem_re) mem_data <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [4:0] wr;
        logic       rdy;
        logic       v;
        logic [7:0] d;
        logic [4:0] rp;
        logic       re;
        logic [3:0] addr;
        logic       e;
        logic [4:0] lvl;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int na;
        int nd;
        int nre;
        logic [3:0] ea [4];
        logic [4:0] er [4];

        // wr, rdy, valid, data, rd_ptr, re, addr, empty, level
        vecs[0] = '{5'd0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 4'd0, 1'b1, 5'd0};
        vecs[1] = '{5'd5, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 4'd0, 1'b0, 5'd5};
        vecs[2] = '{5'd5, 1'b1, 1'b0, 8'h00, 5'd1, 1'b1, 4'd1, 1'b0, 5'd4};
        vecs[3] = '{5'd5, 1'b1, 1'b1, 8'h11, 5'd2, 1'b1, 4'd2, 1'b0, 5'd3};
        vecs[4] = '{5'd5, 1'b1, 1'b1, 8'h12, 5'd3, 1'b1, 4'd3, 1'b0, 5'd2};
        vecs[5] = '{5'd5, 1'b1, 1'b1, 8'h13, 5'd4, 1'b1, 4'd4, 1'b0, 5'd1};
        vecs[6] = '{5'd5, 1'b1, 1'b1, 8'h14, 5'd5, 1'b0, 4'd5, 1'b1, 5'd0};
        vecs[7] = '{5'd5, 1'b1, 1'b1, 8'h15, 5'd5, 1'b0, 4'd5, 1'b1, 5'd0};
        vecs[8] = '{5'd5, 1'b1, 1'b0, 8'h15, 5'd5, 1'b0, 4'd5, 1'b1, 5'd0};

        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        for (int i = 0; i < 5; i++) mem[i] = 8'h11 + 8'(i);

        rst_n  = 1'b0;
        wr_ptr = '0;
        flush  = 1'b0;
        ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic stream of five words, one per cycle
        for (int i = 0; i < 9; i++) begin
            wr_ptr = vecs[i].wr;
            ready  = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d valid", i), 32'(valid),    32'(vecs[i].v));
            chk($sformatf("vec%0d data", i),  32'(data),     32'(vecs[i].d));
            chk($sformatf("vec%0d rd_ptr", i), 32'(rd_ptr),  32'(vecs[i].rp));
            chk($sformatf("vec%0d mem_re", i), 32'(mem_re),  32'(vecs[i].re));
            chk($sformatf("vec%0d addr", i),  32'(mem_addr), 32'(vecs[i].addr));
            chk($sformatf("vec%0d empty", i), 32'(empty),    32'(vecs[i].e));
            chk($sformatf("vec%0d level", i), 32'(level),    32'(vecs[i].lvl));
            step();
        end

        // Back-pressure: ten words queued, consumer stalled for six cycles
        for (int i = 0; i < 10; i++) mem[5 + i] = 8'h20 + 8'(i);
        wr_ptr = 5'd15;
        ready  = 1'b0;
        nre    = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (mem_re) nre++;
            step();
        end
        #1;
        chk("bp reads issued", 32'(nre), 32'd2);
        chk("bp rd_ptr", 32'(rd_ptr), 32'd7);
        chk("bp level", 32'(level), 32'd8);
        chk("bp mem_re", 32'(mem_re), 32'd0);
        chk("bp valid", 32'(valid), 32'd1);
        chk("bp data held", 32'(data), 32'h20);
        ready = 1'b1;
        #1;
        chk("bp restart issue", 32'(mem_re), 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp out%0d valid", i), 32'(valid), 32'd1);
            chk($sformatf("bp out%0d data", i), 32'(data), 32'h20 + 32'(i));
            step();
        end
        chk("bp drained valid", 32'(valid), 32'd0);
        chk("bp final rd_ptr", 32'(rd_ptr), 32'd15);
        chk("bp final empty", 32'(empty), 32'd1);

        // Wrap: flush to pointer 30, then four words across the wrap
        wr_ptr = 5'd30;
        flush  = 1'b1;
        step();
        flush = 1'b0;
        chk("wrap flush rd_ptr", 32'(rd_ptr), 32'd30);
        chk("wrap flush valid", 32'(valid), 32'd0);
        mem[14] = 8'h41;
        mem[15] = 8'h42;
        mem[0]  = 8'h43;
        mem[1]  = 8'h44;
        ea[0] = 4'd14; ea[1] = 4'd15; ea[2] = 4'd0; ea[3] = 4'd1;
        er[0] = 5'd30; er[1] = 5'd31; er[2] = 5'd0; er[3] = 5'd1;
        wr_ptr = 5'd2;
        ready  = 1'b1;
        #1;
        chk("wrap level", 32'(level), 32'd4);
        na = 0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            if (mem_re) begin
                if (na < 4) begin
                    chk($sformatf("wrap addr%0d", na), 32'(mem_addr), 32'(ea[na]));
                    chk($sformatf("wrap rd_ptr%0d", na), 32'(rd_ptr), 32'(er[na]));
                end
                na++;
            end
            if (valid) begin
                chk($sformatf("wrap data%0d", nd), 32'(data), 32'h41 + 32'(nd));
                nd++;
            end
            step();
        end
        chk("wrap reads", 32'(na), 32'd4);
        chk("wrap words", 32'(nd), 32'd4);
        chk("wrap end rd_ptr", 32'(rd_ptr), 32'd2);
        chk("wrap end empty", 32'(empty), 32'd1);

        // Flush with one word buffered and one in flight
        for (int i = 0; i < 7; i++) mem[2 + i] = 8'h50 + 8'(i);
        wr_ptr = 5'd9;
        ready  = 1'b0;
        step();
        step();
        chk("fl pre valid", 32'(valid), 32'd1);
        chk("fl pre data", 32'(data), 32'h50);
        chk("fl pre mem_re", 32'(mem_re), 32'd0);
        flush = 1'b1;
        #1;
        chk("fl gates mem_re", 32'(mem_re), 32'd0);
        step();
        flush = 1'b0;
        chk("fl valid", 32'(valid), 32'd0);
        chk("fl rd_ptr", 32'(rd_ptr), 32'd9);
        chk("fl empty", 32'(empty), 32'd1);
        chk("fl level", 32'(level), 32'd0);
        chk("fl head kept", 32'(data), 32'h50);
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("fl no return %0d", i), 32'(valid), 32'd0);
        end

        // Asynchronous reset in the middle of a stream
        for (int i = 0; i < 3; i++) mem[9 + i] = 8'h60 + 8'(i);
        wr_ptr = 5'd12;
        ready  = 1'b0;
        step();
        step();
        step();
        chk("rst pre valid", 32'(valid), 32'd1);
        chk("rst pre data", 32'(data), 32'h60);
        rst_n = 1'b0;
        #0.5;
        chk("rst valid", 32'(valid), 32'd0);
        chk("rst rd_ptr", 32'(rd_ptr), 32'd0);
        chk("rst data", 32'(data), 32'd0);
        chk("rst mem_re", 32'(mem_re), 32'd0);
        #0.5;
        rst_n = 1'b1;
        #0.5;
        chk("post rst mem_re", 32'(mem_re), 32'd1);
        chk("post rst addr", 32'(mem_addr), 32'd0);
        chk("post rst level", 32'(level), 32'd12);
        step();
        chk("post rst rd_ptr", 32'(rd_ptr), 32'd1);
        step();
        chk("post rst valid", 32'(valid), 32'd1);
        chk("post rst data", 32'(data), 32'h43);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
